// File: rtl/multicycle_control.sv
// multicycle_control
// Sequencing controller for the multi-cycle LEGv8-subset core. Walks each
// instruction through FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and drives the
// shared-datapath enables. It also counts retired instructions, meaning one
// count per pc_write pulse.
//
// Ports
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   run            start permission, looked at only in FETCH
//   instr          instruction register contents, valid from DECODE onward
//   zero           ALU zero flag, used by CBZ in EXEC
//   imem_ack       instruction-memory completion
//   dmem_ack       data-memory completion
//   imem_req       instruction-fetch request
//   ir_load        instruction-register load strobe
//   dmem_req       data-memory request
//   dmem_we        data-memory write (store)
//   ext_sel        sign-extend format: 11 D imm9, 10 CB imm19, 00 B imm26
//   alu_op         00 add, 01 pass-B, 10 R-type funct
//   reg_write      register-file write strobe
//   mem_to_reg     write-back source: 1 memory, 0 ALU
//   pc_write       PC update strobe
//   pc_src         PC source: 0 PC+4, 1 PC+(sext<<2)
//   state          current state encoding (debug)
//   instr_count    retired-instruction count, wraps
//
// Handshake: imem_req and dmem_req are levels. Each request stays high every
// cycle until its ack is seen high at a rising edge, and it drops in the next
// cycle. An ack that arrives while no request of its kind is pending is
// ignored. This covers imem_ack outside FETCH or with run=0, and dmem_ack
// outside MEM.
module multicycle_control #(
  parameter int INSTR_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  input  logic [31:0]            instr,
  input  logic                   zero,
  input  logic                   imem_ack,
  input  logic                   dmem_ack,
  output logic                   imem_req,
  output logic                   ir_load,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [1:0]             ext_sel,
  output logic [1:0]             alu_op,
  output logic                   reg_write,
  output logic                   mem_to_reg,
  output logic                   pc_write,
  output logic                   pc_src,
  output logic [2:0]             state,
  output logic [INSTR_CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  // Instruction class, taken from instr[31:30].
  localparam logic [1:0] CLS_B  = 2'b00;
  localparam logic [1:0] CLS_R  = 2'b01;
  localparam logic [1:0] CLS_CB = 2'b10;
  localparam logic [1:0] CLS_D  = 2'b11;

  localparam logic [INSTR_CNT_W-1:0] CNT_ONE = {{(INSTR_CNT_W-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [1:0]             cls_q;
  logic                   ld_q;     // D-format only: 1 LDUR, 0 STUR
  logic [1:0]             ext_q;
  logic [INSTR_CNT_W-1:0] count_q;

  function automatic logic [1:0] ext_of(input logic [1:0] cls);
    case (cls)
      CLS_D:   ext_of = 2'b11;
      CLS_CB:  ext_of = 2'b10;
      default: ext_of = 2'b00;  // B uses imm26; R does not use the extender
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cls_q   <= CLS_B;
      ld_q    <= 1'b0;
      ext_q   <= 2'b00;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      // The IR is first valid in DECODE. Capture the class there so that
      // every later output is decoded from registered state only. ext_sel
      // then stays put until the next DECODE.
      if (state_q == S_DECODE) begin
        cls_q <= instr[31:30];
        ld_q  <= instr[22];
        ext_q <= ext_of(instr[31:30]);
      end
      if (pc_write) count_q <= count_q + CNT_ONE;
    end
  end

  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req = run;
        ir_load  = run & imem_ack;
        if (run && imem_ack) state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (cls_q)
          CLS_R: begin
            alu_op  = 2'b10;
            state_d = S_WB;
          end
          CLS_D: begin
            alu_op  = 2'b00;
            state_d = S_MEM;
          end
          CLS_CB: begin
            alu_op   = 2'b01;
            pc_write = 1'b1;
            pc_src   = zero;  // branch taken only when the register is zero
            state_d  = S_FETCH;
          end
          default: begin  // B
            pc_write = 1'b1;
            pc_src   = 1'b1;
            state_d  = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = ~ld_q;
        if (dmem_ack) begin
          if (ld_q) begin
            state_d = S_WB;
          end else begin
            // A store retires here because it has no write-back step.
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = ld_q;
        pc_write   = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign state       = state_q;
  assign ext_sel     = ext_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          run;
  logic [31:0]   instr;
  logic          zero;
  logic          imem_ack;
  logic          dmem_ack;
  logic          imem_req;
  logic          ir_load;
  logic          dmem_req;
  logic          dmem_we;
  logic [1:0]    ext_sel;
  logic [1:0]    alu_op;
  logic          reg_write;
  logic          mem_to_reg;
  logic          pc_write;
  logic          pc_src;
  logic [2:0]    state;
  logic [CW-1:0] instr_count;

  int n_checks = 0;
  int n_pass   = 0;

  multicycle_control #(.INSTR_CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .instr(instr), .zero(zero),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req),
    .ir_load(ir_load), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ext_sel(ext_sel), .alu_op(alu_op), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .pc_write(pc_write), .pc_src(pc_src),
    .state(state), .instr_count(instr_count)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Expected output vector:
  // {state, imem_req, ir_load, dmem_req, dmem_we, alu_op, reg_write, mem_to_reg, pc_write, pc_src}
  function automatic logic [31:0] ov(input logic [2:0] st, input logic ireq, input logic irl,
                                     input logic dreq, input logic dwe, input logic [1:0] alu,
                                     input logic rw, input logic m2r, input logic pw,
                                     input logic ps);
    ov = {18'd0, st, ireq, irl, dreq, dwe, alu, rw, m2r, pw, ps};
  endfunction

  function automatic logic [31:0] obs();
    obs = {18'd0, state, imem_req, ir_load, dmem_req, dmem_we, alu_op,
           reg_write, mem_to_reg, pc_write, pc_src};
  endfunction

  // Drivers: tick moves to 1 time unit after the rising edge. Inputs are
  // driven there, and checks are made one unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // B instruction with immediate ack: 3 cycles
  task automatic do_b(input string tag);
    tick(); run = 1'b1; imem_ack = 1'b1; instr = 32'h0000_0000; settle();
    check({tag, "_f"}, obs(), ov(3'd0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0));
    tick(); imem_ack = 1'b0; settle();
    check({tag, "_d"}, obs(), ov(3'd1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    tick(); settle();
    check({tag, "_e"}, obs(), ov(3'd2, 0, 0, 0, 0, 2'b00, 0, 0, 1, 1));
    check({tag, "_ext"}, {30'd0, ext_sel}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; instr = 32'h0; zero = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0;

    // reset values
    #12;
    check("rst_out", obs(), ov(3'd0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    check("rst_cnt", {28'd0, instr_count}, 32'd0);
    check("rst_ext", {30'd0, ext_sel}, 32'd0);
    tick(); rst_n = 1'b1;

    // R-type, a spurious dmem_ack arrives in EXEC
    tick(); run = 1'b1; imem_ack = 1'b1; instr = 32'h4000_0000; settle();
    check("r_fetch", obs(), ov(3'd0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0));
    tick(); imem_ack = 1'b0; settle();
    check("r_dec", obs(), ov(3'd1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    tick(); dmem_ack = 1'b1; settle();
    check("r_exec", obs(), ov(3'd2, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0));
    tick(); dmem_ack = 1'b0; settle();
    check("r_wb", obs(), ov(3'd4, 0, 0, 0, 0, 2'b00, 1, 0, 1, 0));
    tick(); run = 1'b0; settle();
    check("r_done", obs(), ov(3'd0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    check("r_cnt", {28'd0, instr_count}, 32'd1);

    // LDUR, ack on the third MEM cycle; a spurious imem_ack arrives in DECODE
    tick(); run = 1'b1; imem_ack = 1'b1; instr = 32'hC040_0000; settle();
    check("ld_fetch", obs(), ov(3'd0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0));
    tick(); settle();
    check("ld_dec", obs(), ov(3'd1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    tick(); imem_ack = 1'b0; settle();
    check("ld_exec", obs(), ov(3'd2, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    check("ld_ext", {30'd0, ext_sel}, 32'd3);
    tick(); settle();
    check("ld_mem1", obs(), ov(3'd3, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0));
    tick(); settle();
    check("ld_mem2", obs(), ov(3'd3, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0));
    tick(); dmem_ack = 1'b1; settle();
    check("ld_mem3", obs(), ov(3'd3, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0));
    tick(); dmem_ack = 1'b0; settle();
    check("ld_wb", obs(), ov(3'd4, 0, 0, 0, 0, 2'b00, 1, 1, 1, 0));
    check("ld_ext_wb", {30'd0, ext_sel}, 32'd3);
    tick(); run = 1'b0; settle();
    check("ld_done", obs(), ov(3'd0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    check("ld_cnt", {28'd0, instr_count}, 32'd2);

    // STUR, immediate ack
    tick(); run = 1'b1; imem_ack = 1'b1; instr = 32'hC000_0000; settle();
    check("st_fetch", obs(), ov(3'd0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0));
    tick(); imem_ack = 1'b0; settle();
    check("st_dec", obs(), ov(3'd1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    tick(); settle();
    check("st_exec", obs(), ov(3'd2, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    tick(); dmem_ack = 1'b1; settle();
    check("st_mem", obs(), ov(3'd3, 0, 0, 1, 1, 2'b00, 0, 0, 1, 0));
    tick(); dmem_ack = 1'b0; run = 1'b0; settle();
    check("st_done", obs(), ov(3'd0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    check("st_cnt", {28'd0, instr_count}, 32'd3);

    // CBZ taken and then not taken
    for (int k = 0; k < 2; k++) begin
      tick(); run = 1'b1; imem_ack = 1'b1; instr = 32'h8000_0000; zero = (k == 0); settle();
      check("cb_fetch", obs(), ov(3'd0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0));
      tick(); imem_ack = 1'b0; settle();
      check("cb_dec", obs(), ov(3'd1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
      tick(); settle();
      check(k == 0 ? "cb_taken" : "cb_not_taken", obs(),
            ov(3'd2, 0, 0, 0, 0, 2'b01, 0, 0, 1, (k == 0) ? 1'b1 : 1'b0));
      check("cb_ext", {30'd0, ext_sel}, 32'd2);
      tick(); run = 1'b0; zero = 1'b0; settle();
      check("cb_done", obs(), ov(3'd0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    end
    check("cb_cnt", {28'd0, instr_count}, 32'd5);

    // run=0 masks imem_ack
    tick(); run = 1'b0; imem_ack = 1'b1; settle();
    check("norun_a", obs(), ov(3'd0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    tick(); settle();
    check("norun_b", obs(), ov(3'd0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    imem_ack = 1'b0;

    // B, then keep retiring B until the 4-bit counter wraps
    do_b("b");
    tick(); run = 1'b0; settle();
    check("b_cnt", {28'd0, instr_count}, 32'd6);
    for (int i = 0; i < 9; i++) do_b("bw");
    tick(); run = 1'b0; settle();
    check("cnt_15", {28'd0, instr_count}, 32'd15);
    do_b("bl");
    tick(); run = 1'b0; settle();
    check("cnt_wrap", {28'd0, instr_count}, 32'd0);

    // Reset in the middle of MEM
    tick(); run = 1'b1; imem_ack = 1'b1; instr = 32'hC040_0000; settle();
    tick(); imem_ack = 1'b0;
    tick();
    tick(); settle();
    check("mr_mem", obs(), ov(3'd3, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0));
    rst_n = 1'b0; run = 1'b0; settle();
    check("mr_async", obs(), ov(3'd0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    check("mr_cnt", {28'd0, instr_count}, 32'd0);
    check("mr_ext", {30'd0, ext_sel}, 32'd0);
    tick(); dmem_ack = 1'b1; settle();
    check("mr_hold", obs(), ov(3'd0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    dmem_ack = 1'b0;
    tick(); rst_n = 1'b1;
    tick(); run = 1'b1; settle();
    check("mr_first_fetch", obs(), ov(3'd0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
